// File: rtl/conv_3x3_channel_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_3x3_channel_acc_pkg
//  Description : Shared definitions for the channel accumulator: default
//                sizing, accumulator state encoding, saturation limits and
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_3x3_channel_acc_pkg;

  // Default geometry, matching the upstream 3x3 convolution top
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int IMAGE_WIDTH_DEF    = 16;
  localparam int IMAGE_HEIGHT_DEF   = 16;
  localparam int CHANNEL_NUM_IN_DEF = 256;
  localparam int IMAGE_SIZE_DEF     = IMAGE_WIDTH_DEF * IMAGE_HEIGHT_DEF;

  // Saturation limits at the default sample width
  localparam logic [DATA_WIDTH_DEF-1:0] C_SAT_MAX_DEF = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
  localparam logic [DATA_WIDTH_DEF-1:0] C_SAT_MIN_DEF = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

  // Which pass over the plane buffer the current input channel belongs to
  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LAST  = 2'd2
  } acc_state_e;

  // Counter width that stays at least one bit for degenerate sizes of 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_acc_plane_ram.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_plane_ram
//  Description : DEPTH x DATA_WIDTH partial-sum plane buffer. One synchronous
//                write port and one asynchronous read port; a write is
//                visible to the read port from the cycle after it lands.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_plane_ram #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Storage is deliberately unreset: the FIRST pass overwrites every entry
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/conv_3x3_channel_acc.sv
`default_nettype none
// ============================================================================
//  Module      : conv_3x3_channel_acc
//  Description : Accumulates CHANNEL_NUM_IN partial-sum planes pixel by pixel
//                with saturating adds, adds the output-channel bias on the
//                last channel and emits the finished plane in raster order.
//                Optional macro CONV_ACC_RELU_EN clamps negative results to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_3x3_channel_acc
  import conv_3x3_channel_acc_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int IMAGE_WIDTH    = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT   = IMAGE_HEIGHT_DEF,
  parameter int CHANNEL_NUM_IN = CHANNEL_NUM_IN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_bias_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  plane_done
);

  localparam int IMAGE_SIZE    = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_WIDTH_PXL = cnt_width(IMAGE_SIZE);
  localparam int CNT_WIDTH_CH  = cnt_width(CHANNEL_NUM_IN);

  localparam logic [CNT_WIDTH_PXL-1:0] C_PXL_LAST = CNT_WIDTH_PXL'(IMAGE_SIZE - 1);
  localparam logic [CNT_WIDTH_CH-1:0]  C_CH_LAST  = CNT_WIDTH_CH'(CHANNEL_NUM_IN - 1);
  localparam logic [DATA_WIDTH-1:0]    C_SAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]    C_SAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // A single-channel layer never leaves the output pass
  localparam acc_state_e C_STATE_RST = (CHANNEL_NUM_IN == 1) ? ST_LAST : ST_FIRST;

  // Signed add that clamps instead of wrapping on overflow
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) sat_add = s[DATA_WIDTH] ? C_SAT_MIN : C_SAT_MAX;
    else                                  sat_add = s[DATA_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH_PXL-1:0] pxl_cnt_q, pxl_cnt_d;
  logic [CNT_WIDTH_CH-1:0]  ch_cnt_q, ch_cnt_d;
  acc_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]    bias_q, bias_d;
  logic [DATA_WIDTH-1:0]    pxl_out_q, pxl_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     plane_done_q, plane_done_d;

  logic                     ram_wr_en;
  logic [DATA_WIDTH-1:0]    ram_wr_data;
  logic [DATA_WIDTH-1:0]    ram_rd_data;
  logic [DATA_WIDTH-1:0]    sum_acc;
  logic [DATA_WIDTH-1:0]    sum_bias;
  logic [DATA_WIDTH-1:0]    result;

  conv_acc_plane_ram #(
    .DEPTH      (IMAGE_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (CNT_WIDTH_PXL)
  ) u_plane_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (pxl_cnt_q),
    .wr_data (ram_wr_data),
    .rd_addr (pxl_cnt_q),
    .rd_data (ram_rd_data)
  );

  // Running partial sum and the biased total; the old bias is used even if a new one arrives this cycle
  assign sum_acc  = sat_add(ram_rd_data, pxl_in);
  assign sum_bias = sat_add(sum_acc, bias_q);

`ifdef CONV_ACC_RELU_EN
  assign result = sum_bias[DATA_WIDTH-1] ? '0 : sum_bias;
`else
  assign result = sum_bias;
`endif

  // Pixel/channel counters and the pass state they imply
  always_comb begin
    pxl_cnt_d = pxl_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    if (valid_in) begin
      if (pxl_cnt_q == C_PXL_LAST) begin
        pxl_cnt_d = '0;
        ch_cnt_d  = (ch_cnt_q == C_CH_LAST) ? '0 : ch_cnt_q + 1'b1;
      end else begin
        pxl_cnt_d = pxl_cnt_q + 1'b1;
      end
    end
    if (ch_cnt_d == C_CH_LAST) state_d = ST_LAST;
    else if (ch_cnt_d == '0)   state_d = ST_FIRST;
    else                       state_d = ST_ACCUM;
  end

  // Buffer write, output register and bias register next values
  always_comb begin
    ram_wr_en    = 1'b0;
    ram_wr_data  = pxl_in;
    pxl_out_d    = pxl_out_q;
    valid_out_d  = 1'b0;
    plane_done_d = 1'b0;
    bias_d       = valid_bias_in ? bias_in : bias_q;
    if (valid_in) begin
      case (state_q)
        ST_FIRST: begin
          ram_wr_en   = 1'b1;
          ram_wr_data = pxl_in;
        end
        ST_ACCUM: begin
          ram_wr_en   = 1'b1;
          ram_wr_data = sum_acc;
        end
        ST_LAST: begin
          pxl_out_d    = result;
          valid_out_d  = 1'b1;
          plane_done_d = (pxl_cnt_q == C_PXL_LAST);
        end
        default: ;
      endcase
    end
  end

  // Control and output registers; reset drops any in-flight output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      state_q      <= C_STATE_RST;
      bias_q       <= '0;
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      plane_done_q <= 1'b0;
    end else begin
      pxl_cnt_q    <= pxl_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      state_q      <= state_d;
      bias_q       <= bias_d;
      pxl_out_q    <= pxl_out_d;
      valid_out_q  <= valid_out_d;
      plane_done_q <= plane_done_d;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign plane_done = plane_done_q;

endmodule
`default_nettype wire
